stage_controller_configurable: RTL and testbench

- Next-generation single-FPGA decoding stage controller.
- Sequences the PE array through measurement loading, grow/merge iterations and peeling, driven by a byte stream.
- Adds three things: runtime-configurable round count and merge settle delay (parameters message), an iteration timeout, and a multi-byte result report streamed out with a valid/ready handshake.
- Sits between the host byte interface and the PE array; drives global_stage to every PE.

---
 rtl/stage_controller_configurable_pkg.sv | 29 ++
 rtl/stage_controller_configurable_result_report_serializer.sv | 60 ++++++
 rtl/stage_controller_configurable.sv | 215 +++++++++++++++++++++
 tb/tb_stage_controller_configurable.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_controller_configurable_pkg.sv
// Shared encodings for the decoding stage controller: broadcast stage values,
// host protocol bytes and the layout of the result report.
package stage_controller_configurable_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                  = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING    = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_PREPARING = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING   = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                  = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE                 = 3'd5;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING               = 3'd6;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID          = 3'd7;

    localparam logic [7:0] START_DECODING_MSG      = 8'h01;
    localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;
    localparam logic [7:0] RESULT_HEADER_MSG       = 8'hA5;

    localparam int REPORT_LENGTH = 7;

    // Fields carried by one result report (header byte is implicit).
    typedef struct packed {
        logic [7:0]  status;
        logic [7:0]  iterations;
        logic [31:0] cycles;
    } report_fields_t;

endpackage

// File: rtl/stage_controller_configurable_result_report_serializer.sv
// Streams the 7-byte result report over a valid/ready byte interface.
// Fields are captured on start so they stay stable however long the host stalls.
module result_report_serializer
    import stage_controller_configurable_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  report_fields_t fields,
    output logic [7:0]     output_data,
    output logic           output_valid,
    input  logic           output_ready,
    output logic           done
);

    localparam int                  IDX_WIDTH = $clog2(REPORT_LENGTH);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(REPORT_LENGTH - 1);

    report_fields_t        fields_q;
    logic [IDX_WIDTH-1:0]  byte_idx;
    logic                  active;

    // Capture fields on start, advance the byte index only on a completed handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fields_q <= '0;
            byte_idx <= '0;
            active   <= 1'b0;
        end else if (start) begin
            fields_q <= fields;
            byte_idx <= '0;
            active   <= 1'b1;
        end else if (active && output_ready) begin
            if (byte_idx == LAST_IDX) begin
                active <= 1'b0;
            end else begin
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

    assign output_valid = active;
    assign done         = active && output_ready && (byte_idx == LAST_IDX);

    // Byte order: header, status, iterations, cycle count little-endian.
    always_comb begin
        output_data = 8'h00;
        case (byte_idx)
            3'd0:    output_data = RESULT_HEADER_MSG;
            3'd1:    output_data = fields_q.status;
            3'd2:    output_data = fields_q.iterations;
            3'd3:    output_data = fields_q.cycles[7:0];
            3'd4:    output_data = fields_q.cycles[15:8];
            3'd5:    output_data = fields_q.cycles[23:16];
            3'd6:    output_data = fields_q.cycles[31:24];
            default: output_data = 8'h00;
        endcase
    end

endmodule

// File: rtl/stage_controller_configurable.sv
// Decoding stage controller: loads runtime parameters and syndrome rounds from
// the host byte stream, sequences GROW/MERGE/PEELING across the PE array with a
// configurable settle delay and iteration timeout, then streams a result report.
module stage_controller_configurable
    import stage_controller_configurable_pkg::*;
#(
    parameter int GRID_WIDTH_X            = 3,
    parameter int GRID_WIDTH_Z            = 2,
    parameter int GRID_WIDTH_U            = 3,
    parameter int ITERATION_COUNTER_WIDTH = 8,
    parameter int MAX_ITERATIONS          = 200,
    parameter int MAXIMUM_DELAY           = 7,
    localparam int PU_PER_ROUND           = GRID_WIDTH_X * GRID_WIDTH_Z,
    localparam int PU_COUNT               = PU_PER_ROUND * GRID_WIDTH_U,
    localparam int BYTES_PER_ROUND        = (PU_PER_ROUND + 7) / 8,
    localparam int ALIGNED_PU_PER_ROUND   = BYTES_PER_ROUND * 8,
    localparam int ROUND_WIDTH            = $clog2(GRID_WIDTH_U + 1)
)(
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      input_data,
    input  logic                            input_valid,
    output logic                            input_ready,
    output logic [7:0]                      output_data,
    output logic                            output_valid,
    input  logic                            output_ready,
    input  logic [PU_COUNT-1:0]             busy_PE,
    input  logic [PU_COUNT-1:0]             odd_clusters_PE,
    output logic [ALIGNED_PU_PER_ROUND-1:0] measurements,
    output logic [ROUND_WIDTH-1:0]          measurement_round,
    output logic [STAGE_WIDTH-1:0]          global_stage
);

    localparam int BYTE_CNT_WIDTH = (BYTES_PER_ROUND > 1) ? $clog2(BYTES_PER_ROUND) : 1;
    localparam int DELAY_WIDTH    = (MAXIMUM_DELAY > 0) ? $clog2(MAXIMUM_DELAY + 1) : 1;
    localparam int ICW            = ITERATION_COUNTER_WIDTH;

    localparam logic [BYTE_CNT_WIDTH-1:0] LAST_BYTE = BYTE_CNT_WIDTH'(BYTES_PER_ROUND - 1);

    logic [STAGE_WIDTH-1:0]          stage;
    logic                            busy_r;
    logic                            odd_r;
    logic [7:0]                      rounds_cfg;
    logic [DELAY_WIDTH-1:0]          delay_cfg;
    logic                            param_idx;
    logic [BYTE_CNT_WIDTH-1:0]       byte_cnt;
    logic [DELAY_WIDTH-1:0]          delay_cnt;
    logic [ICW-1:0]                  iter_cnt;
    logic [31:0]                     cycle_cnt;
    logic                            timeout_flag;
    logic                            odd_at_exit;
    logic                            report_start;
    logic                            report_done;
    logic                            in_fire;
    logic                            delay_done;
    logic [7:0]                      round_plus1;
    logic [ALIGNED_PU_PER_ROUND-1:0] meas_shifted;
    report_fields_t                  report_fields;

    assign global_stage = stage;
    assign input_ready  = (stage == STAGE_IDLE) || (stage == STAGE_PARAMETERS_LOADING) ||
                          (stage == STAGE_MEASUREMENT_PREPARING);
    assign in_fire      = input_valid && input_ready;
    assign delay_done   = (delay_cnt >= delay_cfg);
    assign round_plus1  = 8'(measurement_round) + 8'd1;

    // New bytes enter at the top of the round word; older bytes move toward bit 0.
    always_comb begin
        meas_shifted = measurements >> 8;
        meas_shifted[ALIGNED_PU_PER_ROUND-1 -: 8] = input_data;
    end

    // OR-reduced PE flags, registered; this covers the first settle cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            odd_r  <= 1'b0;
        end else begin
            busy_r <= |busy_PE;
            odd_r  <= |odd_clusters_PE;
        end
    end

    // Main stage sequencer with its configuration and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage             <= STAGE_IDLE;
            rounds_cfg        <= 8'(GRID_WIDTH_U);
            delay_cfg         <= DELAY_WIDTH'(MAXIMUM_DELAY);
            param_idx         <= 1'b0;
            byte_cnt          <= '0;
            delay_cnt         <= '0;
            iter_cnt          <= '0;
            cycle_cnt         <= '0;
            timeout_flag      <= 1'b0;
            odd_at_exit       <= 1'b0;
            report_start      <= 1'b0;
            measurements      <= '0;
            measurement_round <= '0;
        end else begin
            report_start <= 1'b0;
            if (((stage == STAGE_GROW) || (stage == STAGE_MERGE) || (stage == STAGE_PEELING)) &&
                (cycle_cnt != 32'hFFFF_FFFF)) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            case (stage)
                STAGE_IDLE: begin
                    if (in_fire) begin
                        if (input_data == START_DECODING_MSG) begin
                            stage     <= STAGE_PARAMETERS_LOADING;
                            param_idx <= 1'b0;
                        end else if (input_data == MEASUREMENT_DATA_HEADER) begin
                            stage             <= STAGE_MEASUREMENT_PREPARING;
                            measurement_round <= '0;
                            byte_cnt          <= '0;
                        end
                    end
                end
                STAGE_PARAMETERS_LOADING: begin
                    if (in_fire) begin
                        if (!param_idx) begin
                            if (input_data == 8'd0)
                                rounds_cfg <= 8'd1;
                            else if (input_data > 8'(GRID_WIDTH_U))
                                rounds_cfg <= 8'(GRID_WIDTH_U);
                            else
                                rounds_cfg <= input_data;
                            param_idx <= 1'b1;
                        end else begin
                            if (input_data > 8'(MAXIMUM_DELAY))
                                delay_cfg <= DELAY_WIDTH'(MAXIMUM_DELAY);
                            else
                                delay_cfg <= DELAY_WIDTH'(input_data);
                            stage <= STAGE_IDLE;
                        end
                    end
                end
                STAGE_MEASUREMENT_PREPARING: begin
                    if (in_fire) begin
                        measurements <= meas_shifted;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            stage    <= STAGE_MEASUREMENT_LOADING;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                STAGE_MEASUREMENT_LOADING: begin
                    measurement_round <= measurement_round + 1'b1;
                    iter_cnt          <= '0;
                    cycle_cnt         <= '0;
                    timeout_flag      <= 1'b0;
                    odd_at_exit       <= 1'b0;
                    stage <= (round_plus1 < rounds_cfg) ? STAGE_MEASUREMENT_PREPARING : STAGE_GROW;
                end
                STAGE_GROW: begin
                    iter_cnt  <= iter_cnt + 1'b1;
                    delay_cnt <= '0;
                    stage     <= STAGE_MERGE;
                end
                STAGE_MERGE: begin
                    if (!delay_done) begin
                        delay_cnt <= delay_cnt + 1'b1;
                    end else if (!busy_r) begin
                        if (!odd_r) begin
                            delay_cnt <= '0;
                            stage     <= STAGE_PEELING;
                        end else if (iter_cnt < ICW'(MAX_ITERATIONS)) begin
                            stage <= STAGE_GROW;
                        end else begin
                            // Still odd after the iteration budget: report without peeling.
                            timeout_flag <= 1'b1;
                            odd_at_exit  <= 1'b1;
                            report_start <= 1'b1;
                            stage        <= STAGE_RESULT_VALID;
                        end
                    end
                end
                STAGE_PEELING: begin
                    if (!delay_done) begin
                        delay_cnt <= delay_cnt + 1'b1;
                    end else if (!busy_r) begin
                        odd_at_exit  <= odd_r;
                        report_start <= 1'b1;
                        stage        <= STAGE_RESULT_VALID;
                    end
                end
                STAGE_RESULT_VALID: begin
                    if (report_done) begin
                        measurement_round <= '0;
                        stage             <= STAGE_IDLE;
                    end
                end
                default: stage <= STAGE_IDLE;
            endcase
        end
    end

    assign report_fields.status     = {6'b0, odd_at_exit, timeout_flag};
    assign report_fields.iterations = 8'(iter_cnt);
    assign report_fields.cycles     = cycle_cnt;

    result_report_serializer u_report (
        .clk          (clk),
        .reset        (reset),
        .start        (report_start),
        .fields       (report_fields),
        .output_data  (output_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .done         (report_done)
    );

endmodule

// File: tb/tb_stage_controller_configurable.sv
// Directed bench for the stage controller: a parameter/timing vector table
// plus hand-written sequences for timeout, backpressure and mid-run reset.
module tb_stage_controller_configurable;
    import stage_controller_configurable_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  input_data;
    logic        input_valid;
    logic        input_ready;
    logic [7:0]  output_data;
    logic        output_valid;
    logic        output_ready;
    logic [17:0] busy_PE;
    logic [17:0] odd_clusters_PE;
    logic [7:0]  measurements;
    logic [1:0]  measurement_round;
    logic [2:0]  global_stage;

    int checks = 0;
    int errors = 0;

    int load_cnt = 0, grow_cnt = 0, merge_cnt = 0, peel_cnt = 0;
    logic [7:0] meas_log  [256];
    logic [1:0] round_log [256];
    logic [7:0] pattern   [3];

    typedef struct {
        logic [7:0] rounds_b;
        logic [7:0] delay_b;
        int         exp_rounds;
        int         exp_settle;
        int         exp_cycles;
    } vec_t;
    vec_t vecs [6];

    stage_controller_configurable #(.MAX_ITERATIONS(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .input_data        (input_data),
        .input_valid       (input_valid),
        .input_ready       (input_ready),
        .output_data       (output_data),
        .output_valid      (output_valid),
        .output_ready      (output_ready),
        .busy_PE           (busy_PE),
        .odd_clusters_PE   (odd_clusters_PE),
        .measurements      (measurements),
        .measurement_round (measurement_round),
        .global_stage      (global_stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Stage occupancy counters and a log of what each LOADING cycle presented.
    always @(negedge clk) begin
        if (reset) begin
            case (global_stage)
                STAGE_MEASUREMENT_LOADING: begin
                    meas_log[load_cnt & 255]  = measurements;
                    round_log[load_cnt & 255] = measurement_round;
                    load_cnt++;
                end
                STAGE_GROW:    grow_cnt++;
                STAGE_MERGE:   merge_cnt++;
                STAGE_PEELING: peel_cnt++;
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        input_data  = b;
        input_valid = 1'b1;
        while (!input_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            chk("input_ready_wait", 32'(n), 32'd0);
        end else begin
            @(posedge clk); #1;
        end
        input_valid = 1'b0;
    endtask

    task automatic send_params(input logic [7:0] r, input logic [7:0] d);
        send_byte(START_DECODING_MSG);
        send_byte(r);
        send_byte(d);
    endtask

    task automatic collect_report(input logic [6:0][7:0] exp, input int stall_idx);
        int n, cyc;
        logic [7:0] got [7];
        n = 0;
        cyc = 0;
        output_ready = 1'b1;
        while (n < 7 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (output_valid) begin
                if (n == stall_idx) begin
                    output_ready = 1'b0;
                    for (int k = 0; k < 10; k++) begin
                        @(negedge clk);
                        chk("stall_valid", 32'(output_valid), 32'd1);
                        chk("stall_data", 32'(output_data), 32'(exp[n]));
                    end
                    output_ready = 1'b1;
                end
                got[n] = output_data;
                n++;
            end
        end
        chk("report_byte_count", 32'(n), 32'd7);
        for (int i = 0; i < n; i++) chk($sformatf("report_byte%0d", i), 32'(got[i]), 32'(exp[i]));
        @(negedge clk);
        chk("post_report_valid", 32'(output_valid), 32'd0);
        chk("post_report_stage", 32'(global_stage), 32'(STAGE_IDLE));
        chk("post_report_round", 32'(measurement_round), 32'd0);
    endtask

    task automatic run_decode(input int nrounds, input logic [7:0] exp_status, input logic [7:0] exp_iter,
                              input logic [31:0] exp_cyc, input int exp_grow, input int exp_merge,
                              input int exp_peel, input int stall_idx, input logic chk_meas);
        int l0, g0, m0, p0;
        logic [6:0][7:0] exp;
        l0 = load_cnt; g0 = grow_cnt; m0 = merge_cnt; p0 = peel_cnt;
        send_byte(MEASUREMENT_DATA_HEADER);
        for (int r = 0; r < nrounds; r++) send_byte(pattern[r % 3]);
        exp = {exp_cyc[31:24], exp_cyc[23:16], exp_cyc[15:8], exp_cyc[7:0], exp_iter, exp_status, RESULT_HEADER_MSG};
        collect_report(exp, stall_idx);
        chk("loading_cycles", 32'(load_cnt - l0), 32'(nrounds));
        chk("grow_cycles", 32'(grow_cnt - g0), 32'(exp_grow));
        chk("merge_cycles", 32'(merge_cnt - m0), 32'(exp_merge));
        chk("peel_cycles", 32'(peel_cnt - p0), 32'(exp_peel));
        if (chk_meas) begin
            for (int r = 0; r < nrounds; r++) begin
                chk($sformatf("meas_round%0d", r), 32'(meas_log[(l0 + r) & 255]), 32'(pattern[r]));
                chk($sformatf("round_idx%0d", r), 32'(round_log[(l0 + r) & 255]), 32'(r));
            end
        end
    endtask

    initial begin
        int n;
        logic [7:0] rpt [4];
        pattern = '{8'h15, 8'h2A, 8'h3F};
        //            rounds  delay  rounds settle cycles
        vecs[0] = '{8'h02, 8'h01, 2, 2, 5};
        vecs[1] = '{8'h09, 8'hFF, 3, 8, 17};
        vecs[2] = '{8'h00, 8'h00, 1, 1, 3};
        vecs[3] = '{8'h01, 8'h03, 1, 4, 9};
        vecs[4] = '{8'h03, 8'h07, 3, 8, 17};
        vecs[5] = '{8'h02, 8'h05, 2, 6, 13};

        reset = 1'b0;
        input_data = 8'h00; input_valid = 1'b0; output_ready = 1'b0;
        busy_PE = '0; odd_clusters_PE = '0;
        repeat (3) @(negedge clk);
        chk("reset_stage", 32'(global_stage), 32'(STAGE_IDLE));
        chk("reset_meas", 32'(measurements), 32'd0);
        chk("reset_round", 32'(measurement_round), 32'd0);
        chk("reset_out_valid", 32'(output_valid), 32'd0);
        chk("idle_input_ready", 32'(input_ready), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        // Defaults (3 rounds, delay 7) with a 10-cycle stall on report byte 2.
        run_decode(3, 8'h00, 8'h01, 32'd17, 1, 8, 8, 2, 1'b1);

        for (int v = 0; v < 6; v++) begin
            send_params(vecs[v].rounds_b, vecs[v].delay_b);
            run_decode(vecs[v].exp_rounds, 8'h00, 8'h01, 32'(vecs[v].exp_cycles), 1,
                       vecs[v].exp_settle, vecs[v].exp_settle, -1, 1'b0);
        end

        // Odd clusters never resolve: 4 grow iterations then timeout, no peeling.
        send_params(8'h01, 8'h00);
        odd_clusters_PE = 18'h00100;
        run_decode(1, 8'h03, 8'h04, 32'd8, 4, 4, 0, -1, 1'b0);
        odd_clusters_PE = '0;

        // Busy holds MERGE and blocks input; reset there clears everything.
        send_params(8'h01, 8'h02);
        busy_PE = 18'h00001;
        send_byte(MEASUREMENT_DATA_HEADER);
        send_byte(8'h15);
        n = 0;
        while (global_stage != STAGE_MERGE && n < 50) begin @(negedge clk); n++; end
        chk("reach_merge", 32'(global_stage), 32'(STAGE_MERGE));
        input_data = START_DECODING_MSG; input_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("busy_hold_stage", 32'(global_stage), 32'(STAGE_MERGE));
            chk("busy_input_ready", 32'(input_ready), 32'd0);
        end
        input_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_merge_stage", 32'(global_stage), 32'(STAGE_IDLE));
        chk("rst_merge_meas", 32'(measurements), 32'd0);
        chk("rst_merge_valid", 32'(output_valid), 32'd0);
        busy_PE = '0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        run_decode(3, 8'h00, 8'h01, 32'd17, 1, 8, 8, -1, 1'b0);

        // Reset while report byte 4 is on the bus.
        send_params(8'h01, 8'h00);
        send_byte(MEASUREMENT_DATA_HEADER);
        send_byte(8'h2A);
        rpt = '{RESULT_HEADER_MSG, 8'h00, 8'h01, 8'h03};
        output_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 200 && n < 5; cyc++) begin
            @(negedge clk);
            if (output_valid) begin
                if (n < 4) chk($sformatf("partial_byte%0d", n), 32'(output_data), 32'(rpt[n]));
                n++;
            end
        end
        chk("partial_reached_byte4", 32'(n), 32'd5);
        chk("byte4_valid", 32'(output_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_report_valid", 32'(output_valid), 32'd0);
        chk("rst_report_stage", 32'(global_stage), 32'(STAGE_IDLE));
        chk("rst_report_round", 32'(measurement_round), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        run_decode(3, 8'h00, 8'h01, 32'd17, 1, 8, 8, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
